// File: rtl/sprite_animator.sv
// Sprite animation engine for the VGA pixel-write port: draw, hold for a number
// of frame ticks, erase, move one pixel diagonally with edge bounce, repeat.
module sprite_animator #(
  parameter int          SCREEN_W        = 160,
  parameter int          SCREEN_H        = 120,
  parameter int          XW              = 8,
  parameter int          YW              = 7,
  parameter int          SPR_W           = 4,
  parameter int          SPR_H           = 4,
  parameter int          DELAY           = 833333,
  parameter int          FRAMES_PER_STEP = 4,
  parameter int          MAX_STEPS       = 0,
  parameter logic [2:0]  BG_COLOUR       = 3'b000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          go,
  input  logic          stop,
  input  logic [XW-1:0] x_start,
  input  logic [YW-1:0] y_start,
  input  logic [2:0]    colour_in,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [2:0]    colour_out,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic [15:0]   step_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAW  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_MOVE  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int PXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int PYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DW  = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int FW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [XW-1:0]  X_MAX      = XW'(SCREEN_W - SPR_W);
  localparam logic [YW-1:0]  Y_MAX      = YW'(SCREEN_H - SPR_H);
  localparam logic [XW-1:0]  X_ONE      = XW'(1);
  localparam logic [YW-1:0]  Y_ONE      = YW'(1);
  localparam logic [PXW-1:0] PX_LAST    = PXW'(SPR_W - 1);
  localparam logic [PYW-1:0] PY_LAST    = PYW'(SPR_H - 1);
  localparam logic [PXW-1:0] PX_ONE     = PXW'(1);
  localparam logic [PYW-1:0] PY_ONE     = PYW'(1);
  localparam logic [DW-1:0]  DELAY_LAST = DW'(DELAY - 1);
  localparam logic [DW-1:0]  DELAY_ONE  = DW'(1);
  localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [FW-1:0]  FRAME_ONE  = FW'(1);
  localparam logic [15:0]    STEP_LIMIT = 16'(MAX_STEPS);

  logic [2:0]     state_r;
  logic [XW-1:0]  pos_x_r;
  logic [YW-1:0]  pos_y_r;
  logic           dir_x_r;   // 1 = moving towards 0
  logic           dir_y_r;
  logic [2:0]     colour_r;
  logic [PXW-1:0] px_r;
  logic [PYW-1:0] py_r;
  logic [DW-1:0]  delay_r;
  logic [FW-1:0]  frame_r;

  logic [XW-1:0]  pos_x_next_s;
  logic [YW-1:0]  pos_y_next_s;
  logic           dir_x_next_s;
  logic           dir_y_next_s;
  logic [15:0]    step_inc_s;

  // Next x position and direction with reflection at either screen edge
  always_comb begin
    pos_x_next_s = pos_x_r;
    dir_x_next_s = dir_x_r;
    if (X_MAX == {XW{1'b0}}) begin
      pos_x_next_s = {XW{1'b0}};
      dir_x_next_s = 1'b0;
    end else if (!dir_x_r && (pos_x_r == X_MAX)) begin
      pos_x_next_s = pos_x_r - X_ONE;
      dir_x_next_s = 1'b1;
    end else if (dir_x_r && (pos_x_r == {XW{1'b0}})) begin
      pos_x_next_s = pos_x_r + X_ONE;
      dir_x_next_s = 1'b0;
    end else if (dir_x_r) begin
      pos_x_next_s = pos_x_r - X_ONE;
    end else begin
      pos_x_next_s = pos_x_r + X_ONE;
    end
  end

  // Next y position and direction, same reflection rule as x
  always_comb begin
    pos_y_next_s = pos_y_r;
    dir_y_next_s = dir_y_r;
    if (Y_MAX == {YW{1'b0}}) begin
      pos_y_next_s = {YW{1'b0}};
      dir_y_next_s = 1'b0;
    end else if (!dir_y_r && (pos_y_r == Y_MAX)) begin
      pos_y_next_s = pos_y_r - Y_ONE;
      dir_y_next_s = 1'b1;
    end else if (dir_y_r && (pos_y_r == {YW{1'b0}})) begin
      pos_y_next_s = pos_y_r + Y_ONE;
      dir_y_next_s = 1'b0;
    end else if (dir_y_r) begin
      pos_y_next_s = pos_y_r - Y_ONE;
    end else begin
      pos_y_next_s = pos_y_r + Y_ONE;
    end
  end

  assign step_inc_s = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;

  // Sequencer: state, sprite position, pixel/delay/frame counters, move count
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      pos_x_r    <= {XW{1'b0}};
      pos_y_r    <= {YW{1'b0}};
      dir_x_r    <= 1'b0;
      dir_y_r    <= 1'b0;
      colour_r   <= 3'b000;
      px_r       <= {PXW{1'b0}};
      py_r       <= {PYW{1'b0}};
      delay_r    <= {DW{1'b0}};
      frame_r    <= {FW{1'b0}};
      step_count <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go) begin
            pos_x_r    <= (x_start > X_MAX) ? X_MAX : x_start;
            pos_y_r    <= (y_start > Y_MAX) ? Y_MAX : y_start;
            dir_x_r    <= 1'b0;
            dir_y_r    <= 1'b0;
            colour_r   <= colour_in;
            px_r       <= {PXW{1'b0}};
            py_r       <= {PYW{1'b0}};
            step_count <= 16'd0;
            state_r    <= S_DRAW;
          end
        end
        S_DRAW, S_ERASE: begin
          if (px_r == PX_LAST) begin
            px_r <= {PXW{1'b0}};
            if (py_r == PY_LAST) begin
              py_r <= {PYW{1'b0}};
              if (state_r == S_DRAW) begin
                delay_r <= DELAY_LAST;
                frame_r <= {FW{1'b0}};
                state_r <= S_WAIT;
              end else begin
                state_r <= S_MOVE;
              end
            end else begin
              py_r <= py_r + PY_ONE;
            end
          end else begin
            px_r <= px_r + PX_ONE;
          end
        end
        S_WAIT: begin
          // stop is honoured only here, where the sprite is fully drawn
          if (stop) begin
            state_r <= S_DONE;
          end else if (delay_r == {DW{1'b0}}) begin
            delay_r <= DELAY_LAST;
            if (frame_r == FRAME_LAST) begin
              state_r <= S_ERASE;
            end else begin
              frame_r <= frame_r + FRAME_ONE;
            end
          end else begin
            delay_r <= delay_r - DELAY_ONE;
          end
        end
        S_MOVE: begin
          pos_x_r    <= pos_x_next_s;
          pos_y_r    <= pos_y_next_s;
          dir_x_r    <= dir_x_next_s;
          dir_y_r    <= dir_y_next_s;
          step_count <= step_inc_s;
          if ((STEP_LIMIT != 16'd0) && (step_inc_s == STEP_LIMIT)) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_DRAW;
          end
        end
        S_DONE: begin
          if (!go) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Registered pixel-port and status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_out      <= {XW{1'b0}};
      y_out      <= {YW{1'b0}};
      colour_out <= 3'b000;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= (state_r == S_DRAW) || (state_r == S_ERASE);
      busy <= (state_r != S_IDLE) && (state_r != S_DONE);
      done <= (state_r == S_DONE);
      if ((state_r == S_DRAW) || (state_r == S_ERASE)) begin
        x_out      <= pos_x_r + XW'(px_r);
        y_out      <= pos_y_r + YW'(py_r);
        colour_out <= (state_r == S_DRAW) ? colour_r : BG_COLOUR;
      end else begin
        x_out      <= {XW{1'b0}};
        y_out      <= {YW{1'b0}};
        colour_out <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Scoreboard bench for sprite_animator: a free-running instance and a
// three-move instance share stimulus; monitors compare every plotted pixel.
module tb_sprite_animator;

  localparam int SW = 8, SH = 6, XW = 4, YW = 3, PW = 2, PH = 2;
  localparam int DLY = 3, FPS = 2;
  localparam int XMAX = SW - PW, YMAX = SH - PH;
  localparam int PERIOD = PW * PH * 2 + DLY * FPS + 1;

  typedef struct { int x; int y; int c; int gap; } pix_t;

  logic clock = 1'b0;
  logic reset_n, go, stop;
  logic [XW-1:0] x_start;
  logic [YW-1:0] y_start;
  logic [2:0] colour_in;

  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic [2:0] c0, c1;
  logic plot0, plot1, busy0, busy1, done0, done1;
  logic [15:0] sc0, sc1;

  pix_t q0[$];
  pix_t q1[$];
  int gap_cnt[2];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sprite_animator #(.SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .SPR_W(PW), .SPR_H(PH),
    .DELAY(DLY), .FRAMES_PER_STEP(FPS), .MAX_STEPS(0), .BG_COLOUR(3'b000)) dut0 (
    .clock(clock), .reset_n(reset_n), .go(go), .stop(stop), .x_start(x_start),
    .y_start(y_start), .colour_in(colour_in), .x_out(x0), .y_out(y0), .colour_out(c0),
    .plot(plot0), .busy(busy0), .done(done0), .step_count(sc0));

  sprite_animator #(.SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .SPR_W(PW), .SPR_H(PH),
    .DELAY(DLY), .FRAMES_PER_STEP(FPS), .MAX_STEPS(3), .BG_COLOUR(3'b000)) dut1 (
    .clock(clock), .reset_n(reset_n), .go(go), .stop(stop), .x_start(x_start),
    .y_start(y_start), .colour_in(colour_in), .x_out(x1), .y_out(y1), .colour_out(c1),
    .plot(plot1), .busy(busy1), .done(done1), .step_count(sc1));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input pix_t p);
    if (ch == 0) q0.push_back(p);
    else q1.push_back(p);
  endtask

  // One whole sprite in raster order; only the first pixel carries a gap check
  task automatic push_sprite(input int ch, input int x, input int y, input int col, input int gap);
    pix_t p;
    for (int j = 0; j < PH; j++) begin
      for (int i = 0; i < PW; i++) begin
        p.x = x + i; p.y = y + j; p.c = col;
        p.gap = (i == 0 && j == 0) ? gap : 0;
        push(ch, p);
      end
    end
  endtask

  // Reference: clamp, then draw/hold/erase/reflect until stop (in draw stop_k) or move limit
  task automatic model_run(input int ch, input int xs, input int ys, input int col,
                           input int stop_k, input int maxs);
    int x, y, dx, dy, gap;
    x = (xs > XMAX) ? XMAX : xs;
    y = (ys > YMAX) ? YMAX : ys;
    dx = 1; dy = 1; gap = -1;
    for (int s = 0; s <= stop_k; s++) begin
      push_sprite(ch, x, y, col, gap);
      if (s == stop_k) break;
      push_sprite(ch, x, y, 0, DLY * FPS);
      if (x + dx < 0 || x + dx > XMAX) dx = -dx;
      if (y + dy < 0 || y + dy > YMAX) dy = -dy;
      x = x + dx; y = y + dy;
      gap = 1;
      if (maxs != 0 && s + 1 == maxs) break;
    end
  endtask

  task automatic mon(input int ch, input logic p, input logic [XW-1:0] xo,
                     input logic [YW-1:0] yo, input logic [2:0] co);
    pix_t e;
    int qs;
    if (p === 1'b1) begin
      qs = (ch == 0) ? q0.size() : q1.size();
      n_checks++;
      if (qs == 0) begin
        n_fail++;
        $display("FAIL ch%0d unexpected_plot: got plot at (%0d,%0d) colour %0d, required no plot",
                 ch, xo, yo, co);
      end else begin
        if (ch == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (int'(xo) != e.x || int'(yo) != e.y || int'(co) != e.c ||
            (e.gap >= 0 && gap_cnt[ch] != e.gap)) begin
          n_fail++;
          $display("FAIL ch%0d pixel: got (%0d,%0d) c%0d gap %0d, required (%0d,%0d) c%0d gap %0d",
                   ch, xo, yo, co, gap_cnt[ch], e.x, e.y, e.c, e.gap);
        end
      end
      gap_cnt[ch] = 0;
    end else begin
      gap_cnt[ch] = gap_cnt[ch] + 1;
    end
  endtask

  always @(negedge clock) begin
    mon(0, plot0, x0, y0, c0);
    mon(1, plot1, x1, y1, c1);
  end

  // Start both engines, raise stop during draw k, and check the finished state
  task automatic run(input int xs, input int ys, input int col, input int k);
    int m1;
    model_run(0, xs, ys, col, k, 0);
    model_run(1, xs, ys, col, k, 3);
    m1 = (k < 3) ? k : 3;
    @(posedge clock); #1;
    x_start = xs[XW-1:0]; y_start = ys[YW-1:0]; colour_in = col[2:0]; go = 1'b1;
    repeat (2 + PERIOD * k) @(posedge clock);
    #1 stop = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (done0 && done1) break;
      @(negedge clock);
    end
    chk("done0", int'(done0), 1);
    chk("done1", int'(done1), 1);
    chk("plot0_done", int'(plot0), 0);
    chk("busy0_done", int'(busy0), 0);
    chk("steps0", int'(sc0), k);
    chk("steps1", int'(sc1), m1);
    stop = 1'b0;
    repeat (3) @(negedge clock);
    chk("go_held_no_restart", int'(done0), 1);
    go = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_done0", int'(done0), 0);
    chk("idle_busy0", int'(busy0), 0);
    chk("idle_done1", int'(done1), 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
  endtask

  initial begin
    pix_t p;
    reset_n = 1'b0; go = 1'b0; stop = 1'b0;
    x_start = '0; y_start = '0; colour_in = 3'b000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_plot", int'(plot0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_x", int'(x0), 0);
    chk("rst_y", int'(y0), 0);
    chk("rst_colour", int'(c0), 0);
    chk("rst_steps", int'(sc0), 0);
    chk("rst_done1", int'(done1), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run(1, 1, 4, 4);
    run(6, 4, 2, 2);
    run(15, 7, 7, 1);

    // Reset after two drawn pixels; the following start begins at pixel 0
    for (int ch = 0; ch < 2; ch++) begin
      p.x = 3; p.y = 2; p.c = 5; p.gap = -1; push(ch, p);
      p.x = 4; p.gap = 0; push(ch, p);
    end
    @(posedge clock); #1;
    x_start = 4'd3; y_start = 3'd2; colour_in = 3'd5; go = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midrst_plot", int'(plot0), 0);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_x", int'(x0), 0);
    chk("midrst_plot1", int'(plot1), 0);
    chk("midrst_q0", q0.size(), 0);
    reset_n = 1'b1; go = 1'b0;
    repeat (2) @(negedge clock);
    run(3, 2, 5, 0);

    for (int r = 0; r < 5; r++) begin
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
Parametrised animation engine that drives the VGA adapter's pixel-write port (x, y, colour, plot). It draws a solid SPR_W x SPR_H sprite and holds it for FRAMES_PER_STEP frame ticks. It then erases the sprite with BG_COLOUR, moves it one pixel diagonally with edge bounce, and redraws. It replaces the fixed-size frame/counter/rate-divider combination with one generic block sized by parameters.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
XW, 8, x coordinate width
YW, 7, y coordinate width
SPR_W, 4, sprite width in pixels (1..SCREEN_W)
SPR_H, 4, sprite height in pixels (1..SCREEN_H)
DELAY, 833333, clock cycles per frame tick (60 Hz at 50 MHz)
FRAMES_PER_STEP, 4, frame ticks between moves (>=1)
MAX_STEPS, 0, number of moves before finishing; 0 = run until stop
BG_COLOUR, 3'b000, erase colour

Ports:
clock  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
go  in  1  start request, level
stop  in  1  finish request, level
x_start  in  XW  initial x, sampled on start
y_start  in  YW  initial y, sampled on start
colour_in  in  3  sprite colour, sampled on start
x_out  out  XW  pixel x to VGA adapter
y_out  out  YW  pixel y to VGA adapter
colour_out  out  3  pixel colour
plot  out  1  pixel write enable
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
step_count  out  16  moves completed since start

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; all outputs 0; position, direction, pixel, delay and frame counters cleared. Reset applies in any state, including mid-draw; plot is 0 on the cycle after the edge.
- All outputs are registered.
- States: IDLE, DRAW, WAIT, ERASE, MOVE, DONE.
- IDLE: when go=1, latch the start values and enter DRAW.
  - pos_x = min(x_start, SCREEN_W-SPR_W); pos_y = min(y_start, SCREEN_H-SPR_H).
  - Latch colour_in; dir_x = dir_y = +1; step_count = 0.
- DRAW / ERASE: emit one pixel per clock, SPR_W*SPR_H consecutive plot=1 cycles, in raster order (px fastest, then py).
  - x_out = pos_x+px; y_out = pos_y+py.
  - colour_out = latched colour in DRAW, BG_COLOUR in ERASE.
  - After the last pixel: DRAW goes to WAIT, ERASE goes to MOVE. plot=0 outside DRAW/ERASE.
- WAIT: delay counter counts DELAY-1 down to 0; each wrap is one frame tick. The frame counter counts ticks.
  - On the FRAMES_PER_STEP-th tick, go to ERASE; both counters reload on entry to WAIT.
  - stop=1 in WAIT: go to DONE on the next edge; the sprite stays drawn.
  - stop is ignored in DRAW/ERASE/MOVE so a sprite is never left half-drawn.
- MOVE: single cycle.
  - x axis: if dir_x=+1 and pos_x==SCREEN_W-SPR_W, then dir_x=-1 and pos_x-=1. If dir_x=-1 and pos_x==0, then dir_x=+1 and pos_x+=1. Otherwise pos_x += dir_x.
  - y axis: same rule with SCREEN_H and SPR_H.
  - If SPR_W==SCREEN_W the x position holds at 0; likewise for y.
  - step_count += 1, saturating at 16'hFFFF.
  - If MAX_STEPS!=0 and the new step_count==MAX_STEPS, go to DONE. The sprite stays erased; this is the end-of-animation blank. Otherwise go to DRAW.
- DONE: done=1, busy=0, plot=0. Return to IDLE when go=0. go held high does not restart.
- Arithmetic: coordinates never leave 0..SCREEN-1; no wrap-around. Pixel counters are sized $clog2 of the sprite dimensions.

Test Plan:
(Bench params unless noted: SCREEN 8x6, SPR 2x2, DELAY=3, FRAMES_PER_STEP=2, MAX_STEPS=0, XW=4, YW=3.)
- Start: reset, then go=1 with x_start=1, y_start=1, colour_in=3'b100 -> 4 plot cycles at (1,1),(2,1),(1,2),(2,2) colour 4. Then plot=0 for exactly 6 cycles (2 ticks x 3). Then 4 erase cycles with colour 0 at the same pixels. Then MOVE, then draw at (2,2); step_count=1.
- Bounce: start x_start=6, y_start=4 -> first draw at (6,4), the edge position. After MOVE the next draw is at (5,3); dir_x=dir_y=-1.
- Clamp: x_start=15, y_start=7 -> first draw origin at (6,4).
- Stop: assert stop during a DRAW -> all 4 pixels complete; DONE on the first WAIT cycle; done=1, plot=0. Release go -> IDLE.
- MAX_STEPS=3 -> after the 3rd ERASE/MOVE, done=1, step_count=3, and no further plot pulses.
- Reset mid-DRAW after 2 pixels -> plot=0, busy=0, x_out=0 on the following cycle. The next go restarts from pixel 0.
